// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the boot-time ROM loader: FSM state encoding,
// frame constants and the running-checksum helper.
package rom_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CNT_HI  = 3'd1,
        CNT_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         BYTES_PER_WORD    = 2;

    // Mod-256 running sum used as the frame checksum.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input handshake and program-memory write port of the ROM loader.
// The loader uses the slave view; the byte source / memory side uses master.
interface rom_loader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [DATA_WIDTH-1:0] prog_data;
    logic                  prog_we;

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, prog_addr, prog_data, prog_we
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, prog_addr, prog_data, prog_we
    );
endinterface

// File: rtl/rom_loader_chk.sv
// Protocol invariants of the ROM loader outputs, kept apart from the design.
module rom_loader_chk (
    input logic clk,
    input logic reset,
    input logic rx_ready,
    input logic prog_we,
    input logic cpu_hold,
    input logic done,
    input logic error
);

    // Memory is only written while the processor is held.
    a_we_hold: assert property (@(posedge clk) disable iff (!reset) prog_we |-> cpu_hold)
        else $error("rom_loader_chk: prog_we while cpu_hold low");

    // A verified frame closes the input and releases the processor.
    a_done_closed: assert property (@(posedge clk) disable iff (!reset)
        done |-> (!rx_ready && !cpu_hold && !error))
        else $error("rom_loader_chk: inconsistent outputs while done");

    // done only clears through reset.
    a_done_sticky: assert property (@(posedge clk) disable iff (!reset) $past(done) |-> done)
        else $error("rom_loader_chk: done dropped without reset");

    // error and done are mutually exclusive.
    a_err_excl: assert property (@(posedge clk) disable iff (!reset) error |-> !done)
        else $error("rom_loader_chk: error and done both set");

endmodule

// File: rtl/rom_loader.sv
// Boot loader: parses SYNC/COUNT/words/CHECKSUM frames, writes words to program
// memory and releases the processor only after the checksum matches.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 12,
    parameter int         DATA_WIDTH = 16,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    rom_loader_if.slave  bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         error
);

    // Largest legal word count; 17 bits so 2^16 is representable.
    localparam logic [16:0] MAX_WORDS = 17'(17'd1 << ADDR_WIDTH);

    state_e                state_r, state_s;
    logic [7:0]            csum_r, csum_s;
    logic [7:0]            count_hi_r, count_hi_s;
    logic [7:0]            hi_byte_r, hi_byte_s;
    logic [15:0]           remaining_r, remaining_s;
    logic [ADDR_WIDTH-1:0] idx_r, idx_s;
    logic [ADDR_WIDTH-1:0] prog_addr_r, prog_addr_s;
    logic [DATA_WIDTH-1:0] prog_data_r, prog_data_s;
    logic                  prog_we_r, prog_we_s;
    logic                  rx_ready_r, rx_ready_s;
    logic                  cpu_hold_r, cpu_hold_s;
    logic                  done_r, done_s;
    logic                  error_r, error_s;
    logic                  xfer_s;
    logic [15:0]           count_s;

    assign xfer_s  = bus.rx_valid && rx_ready_r;
    assign count_s = {count_hi_r, bus.rx_data};

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_s     = state_r;
        csum_s      = csum_r;
        count_hi_s  = count_hi_r;
        hi_byte_s   = hi_byte_r;
        remaining_s = remaining_r;
        idx_s       = idx_r;
        prog_addr_s = prog_addr_r;
        prog_data_s = prog_data_r;
        prog_we_s   = 1'b0;

        if (xfer_s) begin
            case (state_r)
                IDLE: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        state_s = CNT_HI;
                        csum_s  = 8'h00;
                    end else begin
                        state_s = IDLE;
                    end
                end
                CNT_HI: begin
                    count_hi_s = bus.rx_data;
                    csum_s     = csum_add(csum_r, bus.rx_data);
                    state_s    = CNT_LO;
                end
                CNT_LO: begin
                    csum_s      = csum_add(csum_r, bus.rx_data);
                    remaining_s = count_s;
                    idx_s       = '0;
                    if ((count_s == 16'd0) || ({1'b0, count_s} > MAX_WORDS)) begin
                        state_s = ERROR;
                    end else begin
                        state_s = DATA_HI;
                    end
                end
                DATA_HI: begin
                    hi_byte_s = bus.rx_data;
                    csum_s    = csum_add(csum_r, bus.rx_data);
                    state_s   = DATA_LO;
                end
                DATA_LO: begin
                    prog_we_s   = 1'b1;
                    prog_addr_s = idx_r;
                    prog_data_s = {hi_byte_r, bus.rx_data};
                    csum_s      = csum_add(csum_r, bus.rx_data);
                    remaining_s = remaining_r - 16'd1;
                    // Index only advances when another word follows, so it never wraps.
                    if (remaining_r == 16'd1) begin
                        state_s = CHECK;
                    end else begin
                        state_s = DATA_HI;
                        idx_s   = idx_r + ADDR_WIDTH'(1);
                    end
                end
                CHECK: begin
                    if (bus.rx_data == csum_r) begin
                        state_s = DONE;
                    end else begin
                        state_s = ERROR;
                    end
                end
                DONE: begin
                    state_s = DONE;
                end
                ERROR: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        state_s = CNT_HI;
                        csum_s  = 8'h00;
                    end else begin
                        state_s = ERROR;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        // Status outputs follow the state being entered, so they update on the same edge.
        rx_ready_s = (state_s != DONE);
        cpu_hold_s = (state_s != DONE);
        done_s     = (state_s == DONE);
        error_s    = (state_s == ERROR);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_r      <= 8'h00;
            count_hi_r  <= 8'h00;
            hi_byte_r   <= 8'h00;
            remaining_r <= 16'd0;
            idx_r       <= '0;
            prog_addr_r <= '0;
            prog_data_r <= '0;
            prog_we_r   <= 1'b0;
            rx_ready_r  <= 1'b0;
            cpu_hold_r  <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            csum_r      <= csum_s;
            count_hi_r  <= count_hi_s;
            hi_byte_r   <= hi_byte_s;
            remaining_r <= remaining_s;
            idx_r       <= idx_s;
            prog_addr_r <= prog_addr_s;
            prog_data_r <= prog_data_s;
            prog_we_r   <= prog_we_s;
            rx_ready_r  <= rx_ready_s;
            cpu_hold_r  <= cpu_hold_s;
            done_r      <= done_s;
            error_r     <= error_s;
        end
    end

    assign bus.rx_ready  = rx_ready_r;
    assign bus.prog_addr = prog_addr_r;
    assign bus.prog_data = prog_data_r;
    assign bus.prog_we   = prog_we_r;
    assign cpu_hold      = cpu_hold_r;
    assign done          = done_r;
    assign error         = error_r;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: stimulus queues expected memory writes,
// a negedge monitor pops and compares them whenever prog_we is seen.
module tb_rom_loader;
    import rom_loader_pkg::*;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int LIMIT = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic cpu_hold, done, error;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_exp;
    logic [7:0]       tx_q[$];

    rom_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rom_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_BYTE(8'hA5)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    rom_loader_chk chk (
        .clk      (clk),
        .reset    (reset),
        .rx_ready (bus.rx_ready),
        .prog_we  (bus.prog_we),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Write monitor: every prog_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (reset && bus.prog_we) begin
            checks_cnt++;
            if (exp_q.size() == 0) begin
                fail_cnt++;
                $display("FAIL unexpected_write actual addr=%h data=%h required=no write",
                         bus.prog_addr, bus.prog_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.prog_addr, bus.prog_data} !== mon_exp) begin
                    fail_cnt++;
                    $display("FAIL write actual addr=%h data=%h required addr=%h data=%h",
                             bus.prog_addr, bus.prog_data, mon_exp[AW+DW-1:DW], mon_exp[DW-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks_cnt++;
        if (act !== req) begin
            fail_cnt++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_status(input string name, input logic d, input logic e,
                                input logic h, input logic r);
        check({name, "_done"},     32'(done),         32'(d));
        check({name, "_error"},    32'(error),        32'(e));
        check({name, "_cpu_hold"}, 32'(cpu_hold),     32'(h));
        check({name, "_rx_ready"}, 32'(bus.rx_ready), 32'(r));
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!bus.rx_ready && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIMIT) begin
            checks_cnt++;
            fail_cnt++;
            $display("FAIL rx_ready_timeout actual=0 required=1 byte=%h", b);
        end
        @(negedge clk);
    endtask

    task automatic send_q(input bit gaps);
        foreach (tx_q[i]) begin
            send_byte(tx_q[i]);
            if (gaps) begin
                bus.rx_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic load_good(input bit gaps);
        exp_q.push_back({12'h000, 16'h1234});
        exp_q.push_back({12'h001, 16'hABCD});
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
        send_q(gaps);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_prog_addr"}, 32'(bus.prog_addr), 32'h0);
        check({name, "_prog_data"}, 32'(bus.prog_data), 32'h0);
        check({name, "_prog_we"},   32'(bus.prog_we),   32'h0);
        check_status(name, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_values(name);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check({name, "_ready_after_release"}, 32'(bus.rx_ready), 32'h1);
    endtask

    initial begin
        logic [7:0]  sum;
        logic [15:0] w;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(bus.rx_ready), 32'h1);

        // Good frame, valid held high.
        load_good(1'b0);
        check_status("good", 1'b1, 1'b0, 1'b0, 1'b0);

        // Input after done is never accepted.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("after_done_ready", 32'(bus.rx_ready), 32'h0);
        end
        bus.rx_valid = 1'b0;
        check_status("after_done", 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset("rst1");

        // Bad checksum, then recovery with a correct frame.
        exp_q.push_back({12'h000, 16'h1234});
        exp_q.push_back({12'h001, 16'hABCD});
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
        send_q(1'b0);
        check_status("bad_csum", 1'b0, 1'b1, 1'b1, 1'b1);
        send_byte(8'hA5);
        bus.rx_valid = 1'b0;
        check("resync_error_clear", 32'(error), 32'h0);
        exp_q.push_back({12'h000, 16'h1234});
        exp_q.push_back({12'h001, 16'hABCD});
        tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
        send_q(1'b0);
        check_status("recover", 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset("rst2");

        // Garbage bytes and rx_valid toggling every other cycle.
        tx_q = '{8'h00, 8'hFF, 8'h3C};
        send_q(1'b1);
        check_status("garbage", 1'b0, 1'b0, 1'b1, 1'b1);
        load_good(1'b1);
        check_status("gaps", 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset("rst3");

        // Count too large, then count zero.
        tx_q = '{8'hA5, 8'h10, 8'h01};
        send_q(1'b0);
        check_status("count_big", 1'b0, 1'b1, 1'b1, 1'b1);
        send_byte(8'hA5);
        bus.rx_valid = 1'b0;
        check("count_resync_error", 32'(error), 32'h0);
        tx_q = '{8'h00, 8'h00};
        send_q(1'b0);
        check_status("count_zero", 1'b0, 1'b1, 1'b1, 1'b1);

        // Maximum count: 4096 words ending at address 0xFFF.
        tx_q = '{8'hA5, 8'h10, 8'h00};
        sum  = 8'h10;
        for (int i = 0; i < 4096; i++) begin
            w = 16'(i * 40503 + 1);
            exp_q.push_back({12'(i), w});
            tx_q.push_back(w[15:8]);
            tx_q.push_back(w[7:0]);
            sum = sum + w[15:8] + w[7:0];
        end
        tx_q.push_back(sum);
        send_q(1'b0);
        check_status("max_count", 1'b1, 1'b0, 1'b0, 1'b0);
        check("max_last_addr", 32'(bus.prog_addr), 32'hFFF);
        do_reset("rst4");

        // Reset mid-frame after the first word, then a full reload.
        exp_q.push_back({12'h000, 16'h1234});
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
        send_q(1'b0);
        do_reset("mid_reset");
        load_good(1'b0);
        check_status("reload", 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("exp_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
